mac_requant: RTL and testbench

- Downstream stage of the MAC engine. Consumes its 32b signed fixed-point result stream.
- Applies an optional round-half-up right shift and optional saturation to OUT_WIDTH bits.
- Packs 32/OUT_WIDTH results per 32b output word with byte strobes, for the HWPE streamer sink.
- Driven by the HWPE control FSM through start/len/shift configuration. Reports done and a saturation counter.

---
 rtl/mac_requant.sv | 152 +++++++++++++++
 tb/tb_mac_requant.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_requant.sv
// mac_requant: rounds, shifts and saturates a 32b MAC result stream and packs it into 32b words with byte strobes
module mac_requant #(
  parameter int OUT_WIDTH = 8,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 enable_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic [4:0]           shift_i,
  input  logic                 round_en_i,
  input  logic                 sat_en_i,
  input  logic [31:0]          d_data_i,
  input  logic                 d_valid_i,
  output logic                 d_ready_o,
  input  logic [3:0]           d_strb_i,
  output logic [31:0]          e_data_o,
  output logic                 e_valid_o,
  input  logic                 e_ready_i,
  output logic [3:0]           e_strb_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [15:0]          sat_cnt_o
);
  localparam int PACK = 32 / OUT_WIDTH;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic signed [32:0] SMAX = 33'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [32:0] SMIN = -SMAX - 33'sd1;
  logic [1:0]           state;
  logic [LEN_WIDTH-1:0] len_q, acc_cnt, out_cnt;
  logic [4:0]           shift_q;
  logic                 round_q, sat_q;
  logic [OUT_WIDTH-1:0] r_q, q;
  logic                 r_q_valid;
  logic [31:0]          word_data;
  logic [3:0]           word_strb, lane_strb;
  logic                 word_valid, word_last;
  logic [1:0]           idx;
  logic [15:0]          sat_cnt;
  logic                 rst, e_hs, word_free, d_hs, wr, last_el, complete, hi, lo;
  logic signed [32:0]   x, rnd, t, y;
  logic [4:0]           lane_sh;
  logic                 unused_strb;
  // handshakes, requantization arithmetic and lane placement
  always_comb begin
    rst         = rst_i | clear_i;
    unused_strb = ^d_strb_i;
    e_valid_o   = enable_i & word_valid;
    e_hs        = e_valid_o & e_ready_i;
    word_free   = ~word_valid | e_hs;
    d_ready_o   = enable_i & (state == RUN) & (~r_q_valid | word_free) & (acc_cnt < len_q);
    d_hs        = d_valid_i & d_ready_o;
    wr          = enable_i & r_q_valid & word_free;
    last_el     = out_cnt == len_q - 1'b1;
    complete    = (idx == 2'(PACK - 1)) | last_el;
    x           = $signed({d_data_i[31], d_data_i});
    rnd         = (round_q && shift_q != 5'd0) ? (33'sd1 <<< (shift_q - 5'd1)) : 33'sd0;
    t           = x + rnd;
    y           = t >>> shift_q;
    hi          = y > SMAX;
    lo          = y < SMIN;
    q           = (sat_q && hi) ? SMAX[OUT_WIDTH-1:0] : (sat_q && lo) ? SMIN[OUT_WIDTH-1:0] : y[OUT_WIDTH-1:0];
    lane_sh     = 5'(int'(idx) * OUT_WIDTH);
    lane_strb   = 4'(((1 << (OUT_WIDTH / 8)) - 1) << (int'(idx) * (OUT_WIDTH / 8)));
    busy_o      = state == RUN;
    done_o      = state == DONE;
    sat_cnt_o   = sat_cnt;
    e_data_o    = word_data;
    e_strb_o    = word_strb;
  end
  // control FSM and job configuration latched on start
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state   <= IDLE;
      len_q   <= '0;
      shift_q <= '0;
      round_q <= 1'b0;
      sat_q   <= 1'b0;
    end else if (enable_i) begin
      if (state == IDLE && start_i) begin
        len_q   <= len_i;
        shift_q <= shift_i;
        round_q <= round_en_i;
        sat_q   <= sat_en_i;
        state   <= (len_i != '0) ? RUN : DONE;
      end else if (state == RUN && e_hs && word_last) begin
        state <= DONE;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
  // accepted/written element counters and saturation counter
  always_ff @(posedge clk_i) begin
    if (rst) begin
      acc_cnt <= '0;
      out_cnt <= '0;
      sat_cnt <= '0;
    end else if (enable_i) begin
      if (state == IDLE && start_i) begin
        acc_cnt <= '0;
        out_cnt <= '0;
        sat_cnt <= '0;
      end else begin
        if (d_hs) acc_cnt <= acc_cnt + 1'b1;
        if (wr) out_cnt <= out_cnt + 1'b1;
        if (d_hs && sat_q && (hi || lo) && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 1'b1;
      end
    end
  end
  // stage 1: requantized element register
  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else if (enable_i) begin
      if (d_hs) begin
        r_q       <= q;
        r_q_valid <= 1'b1;
      end else if (wr) begin
        r_q_valid <= 1'b0;
      end
    end
  end
  // stage 2: word packing; a full word restarts from lane 0 with other lanes cleared
  always_ff @(posedge clk_i) begin
    if (rst) begin
      word_data  <= '0;
      word_strb  <= '0;
      word_valid <= 1'b0;
      word_last  <= 1'b0;
      idx        <= '0;
    end else if (enable_i) begin
      if (wr) begin
        word_data  <= (word_valid ? 32'd0 : word_data) | (32'(r_q) << lane_sh);
        word_strb  <= (word_valid ? 4'd0 : word_strb) | lane_strb;
        word_valid <= complete;
        word_last  <= last_el;
        idx        <= complete ? 2'd0 : idx + 1'b1;
      end else if (e_hs) begin
        word_data  <= '0;
        word_strb  <= '0;
        word_valid <= 1'b0;
        word_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mac_requant.sv
// tb_mac_requant: directed vectors with hand-computed results for mac_requant
module tb_mac_requant;
  logic        clk = 1'b0, rst = 1'b1, clear = 1'b0, enable = 1'b1, start = 1'b0;
  logic [15:0] len = '0;
  logic [4:0]  shift = '0;
  logic        round_en = 1'b0, sat_en = 1'b0;
  logic [31:0] d_data = '0;
  logic        d_valid = 1'b0, d_ready;
  logic [3:0]  d_strb = 4'hF;
  logic [31:0] e_data;
  logic        e_valid, e_ready = 1'b1;
  logic [3:0]  e_strb;
  logic        busy, done;
  logic [15:0] sat_cnt;
  int          n_chk = 0, n_pass = 0, done_cnt = 0, acc_total = 0;
  logic [31:0] vin [8];
  logic [31:0] q_data [$];
  logic [3:0]  q_strb [$];

  always #5 clk = ~clk;

  mac_requant dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(enable), .start_i(start),
    .len_i(len), .shift_i(shift), .round_en_i(round_en), .sat_en_i(sat_en),
    .d_data_i(d_data), .d_valid_i(d_valid), .d_ready_o(d_ready), .d_strb_i(d_strb),
    .e_data_o(e_data), .e_valid_o(e_valid), .e_ready_i(e_ready), .e_strb_o(e_strb),
    .busy_o(busy), .done_o(done), .sat_cnt_o(sat_cnt)
  );

  always @(posedge clk) begin
    if (e_valid && e_ready) begin
      q_data.push_back(e_data);
      q_strb.push_back(e_strb);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (d_valid && d_ready) acc_total <= acc_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic start_job(input int n, input int sh, input logic r, input logic s);
    len = 16'(n);
    shift = 5'(sh);
    round_en = r;
    sat_en = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int n);
    int i = 0;
    int cyc = 0;
    while (i < n && cyc < 300) begin
      d_valid = 1'b1;
      d_data = vin[i];
      #4;
      if (d_ready) i++;
      @(negedge clk);
      cyc++;
    end
    d_valid = 1'b0;
    chk("feed_cnt", i, n);
  endtask

  task automatic wait_done(input int target);
    int cyc = 0;
    while (done_cnt < target && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_wait", done_cnt, target);
  endtask

  task automatic stall();
    int cyc = 0;
    int a0;
    logic [31:0] w;
    logic stable = 1'b1;
    while (!e_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_seen", e_valid, 1);
    w = e_data;
    a0 = acc_total;
    repeat (10) begin
      @(negedge clk);
      if (e_data !== w || !e_valid) stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    chk("bp_data", w, 32'h04030201);
    chk("bp_ready", d_ready, 0);
    chk("bp_acc", 32'(acc_total - a0 <= 2), 1);
    e_ready = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", e_valid, 0);
    chk("rst_data", e_data, 0);
    chk("rst_strb", e_strb, 0);
    chk("rst_ready", d_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat_cnt, 0);

    vin = '{32'h100, 32'h108, 32'hFFFFFEF8, 32'h7FFFFFFF, 32'h20, 32'h0, 32'h0, 32'h0};
    start_job(4, 4, 1'b1, 1'b1);
    chk("t1_busy", busy, 1);
    feed(4);
    wait_done(1);
    repeat (3) @(negedge clk);
    chk("t1_done_once", done_cnt, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_words", q_data.size(), 1);
    chk("t1_data", q_data[0], 32'h7FF01110);
    chk("t1_strb", q_strb[0], 4'hF);
    chk("t1_sat", sat_cnt, 1);
    q_data.delete();
    q_strb.delete();

    start_job(5, 4, 1'b1, 1'b1);
    feed(5);
    wait_done(2);
    chk("t2_words", q_data.size(), 2);
    chk("t2_data0", q_data[0], 32'h7FF01110);
    chk("t2_data1", q_data[1], 32'h00000002);
    chk("t2_strb1", q_strb[1], 4'h1);
    q_data.delete();
    q_strb.delete();

    vin = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
    e_ready = 1'b0;
    start_job(8, 0, 1'b0, 1'b1);
    fork
      feed(8);
      stall();
    join
    wait_done(3);
    chk("t3_words", q_data.size(), 2);
    chk("t3_data0", q_data[0], 32'h04030201);
    chk("t3_data1", q_data[1], 32'h08070605);
    chk("t3_strb1", q_strb[1], 4'hF);
    q_data.delete();
    q_strb.delete();

    vin[0] = 32'h7FFFFFFF;
    vin[1] = 32'hFFFFFF38;
    start_job(2, 0, 1'b0, 1'b0);
    feed(2);
    wait_done(4);
    chk("t4_words", q_data.size(), 1);
    chk("t4_wrap", q_data[0], 32'h000038FF);
    chk("t4_strb", q_strb[0], 4'h3);
    chk("t4_sat0", sat_cnt, 0);
    q_data.delete();
    q_strb.delete();
    start_job(2, 0, 1'b0, 1'b1);
    feed(2);
    wait_done(5);
    chk("t4_clip", q_data[0], 32'h0000807F);
    chk("t4_sat2", sat_cnt, 2);
    q_data.delete();
    q_strb.delete();

    start_job(0, 0, 1'b0, 1'b0);
    chk("t5_done", done, 1);
    chk("t5_busy", busy, 0);
    @(negedge clk);
    chk("t5_done_off", done, 0);
    chk("t5_words", q_data.size(), 0);

    vin = '{32'h100, 32'h108, 32'hFFFFFEF8, 32'h7FFFFFFF, 32'h20, 32'h0, 32'h0, 32'h0};
    start_job(4, 4, 1'b1, 1'b1);
    feed(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_valid", e_valid, 0);
    chk("t6_data", e_data, 0);
    chk("t6_strb", e_strb, 0);
    chk("t6_ready", d_ready, 0);
    chk("t6_busy", busy, 0);
    chk("t6_sat", sat_cnt, 0);
    chk("t6_words", q_data.size(), 0);
    start_job(4, 4, 1'b1, 1'b1);
    feed(4);
    wait_done(7);
    chk("t6_words2", q_data.size(), 1);
    chk("t6_data2", q_data[0], 32'h7FF01110);
    chk("t6_strb2", q_strb[0], 4'hF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
